ibuf_multiway: RTL
==================

// Module: ibuf_multiway
// PURPOSE
//  Parametrised N-way in-order instruction buffer between decode and issue. Accepts 0..WAYS
//  decoded ops per cycle, presents up to WAYS oldest ops to issue, and retires 0..WAYS per cycle.
//  Payload is opaque (packed by the caller). Adds overflow/underflow clamping, a per-entry interrupt
//  tag, and an occupancy output for the frontend throttle.
// PARAMETERS
//  WAYS          2    lanes in/out; power of 2, 2..4
//  DEPTH         8    entries per way bank; power of 2; capacity CAP = WAYS*DEPTH
//  WIDTH         188  payload bits per op
//  READY_MARGIN  6    free entries that must remain for i_ready=1 (covers in-flight fetches)
//  DT_WIDTH      256  difftest sideband bits per op (used only with DIFFTEST_EN)
// PORTS
//  clk          in   1                      clock
//  reset        in   1                      asynchronous, active-high
//  flush        in   1                      synchronous clear of all entries
//  interrupt    in   1                      tag the first op written this cycle as interrupted
//  i_size       in   $clog2(WAYS+1)         number of ops presented on i_data[0..i_size-1]
//  i_data       in   WAYS x WIDTH           input ops, lane 0 oldest
//  i_ready      out  1                      free entries >= READY_MARGIN + WAYS
//  o_valid      out  WAYS                   o_valid[k] = (count > k)
//  o_data       out  WAYS x WIDTH           oldest ops, lane 0 oldest
//  o_int        out  WAYS                   interrupt tag of each output lane
//  o_size       in   $clog2(WAYS+1)         number of ops consumed this cycle
//  o_count      out  $clog2(CAP+1)          current occupancy
//  o_overflow   out  1                      sticky: ops dropped because buffer full
// BEHAVIOUR
//  - Storage: WAYS banks, each DEPTH deep with own head/tail pointer; a rotating bank index
//    (head_bank, tail_bank, width $clog2(WAYS)) selects where lane 0 lands/reads.
//  - Write: accepted n_in = min(i_size, CAP - count + n_out). Op k goes to bank (tail_bank+k)%WAYS
//    at that bank's tail; bank tail incremented once per op written to it; tail_bank += n_in mod WAYS.
//  - Read: n_out = min(o_size, count). Lane k output = bank (head_bank+k)%WAYS at its head,
//    combinational from registers (0-cycle read latency). Pointers advance as for write.
//  - Data written at cycle t is visible on o_data at t+1 (no same-cycle bypass).
//  - count_next = count + n_in - n_out; simultaneous read/write at full is legal (reads free slots
//    first, so a full buffer with o_size=WAYS accepts WAYS new ops).
//  - i_ready = (CAP - count) >= READY_MARGIN + WAYS; registered inputs not required.
//  - i_size > accepted: excess ops dropped, o_overflow set, cleared only by reset/flush.
//  - o_size > count: clamped, no pointer corruption (assertion fires in simulation).
//  - interrupt: int bit set on the entry for lane 0 iff n_in >= 1; otherwise interrupt is ignored
//    (caller must hold it). Other lanes' int bits = 0.
//  - Pointer wrap: all pointers wrap modulo their width; no special case at DEPTH-1.
//  - flush: next cycle count=0, all pointers 0, o_overflow=0; input in the same cycle discarded;
//    flush has priority over every other event.
//  - Reset (async assert, sync release): count=0, pointers=0, o_overflow=0, so o_valid=0,
//    i_ready=1, o_count=0. Payload RAM not reset; o_data/o_int undefined while o_valid=0.
//  - Reset mid-operation: contents lost, identical to post-reset state.
// CONFIGURATION
//  DIFFTEST_EN defined: ports i_dt/o_dt (WAYS x DT_WIDTH) added; sideband stored in parallel
//    banks with identical pointer/clamp behaviour, not reset.
//  DIFFTEST_EN undefined: ports and storage absent; all other behaviour identical.
// STRUCTURE
//  - definitions.svh: ibuf lane-count typedef, CAP/pointer-width helper constants, INT excp code
//    stays there for the caller's packing.
//  - Sub-module ibuf_way_bank: one DEPTH x (WIDTH+1) bank with wr_en/rd_en, own head/tail,
//    flush and async reset; instantiated WAYS times via generate. Top holds rotation + count logic.
// TESTING (WAYS=2, DEPTH=8, READY_MARGIN=6 unless noted)
//  1. Reset, i_size=2 ops A,B; next cycle o_valid=2'b11, o_data={B,A}, o_count=2; o_size=1 ->
//     next o_data[0]=B, o_valid=2'b01.
//  2. Odd rotation: write 1,2,1 ops (A;B,C;D), consume 1 per cycle -> A,B,C,D in order,
//     banks alternate correctly across pointer wrap after 20 ops.
//  3. Fill to 16; i_ready=0 from count>=9; i_size=2,o_size=0 -> o_overflow=1, count stays 16;
//     i_size=2,o_size=2 at full -> count 16, no overflow change.
//  4. count=1, o_size=2 -> count 0, o_valid=0, next write appears at lane 0 correctly.
//  5. interrupt=1 with i_size=2 -> o_int={0,1}; interrupt=1 with i_size=0 -> no entry tagged.
//  6. flush with i_size=2 and count=5 -> next cycle count=0, o_valid=0; async reset pulsed
//     mid-cycle -> outputs reset immediately; WAYS=4 run of test 2 passes.

Source files
------------

// File: rtl/ibuf_multiway_pkg.sv
// Shared constants and helpers for the multi-way instruction buffer.
package ibuf_multiway_pkg;

  // Lane count type, wide enough for up to 4 ways.
  typedef logic [2:0] ibuf_lanes_t;

  // Exception code the caller packs into the payload of an interrupted op.
  localparam logic [4:0] INT_EXCP_CODE = 5'd0;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ibuf_multiway_way_bank.sv
// One way bank of the instruction buffer: DEPTH x W storage with private head/tail.
module ibuf_multiway_way_bank
  import ibuf_multiway_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 189
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data
);
  localparam int PW = idx_w(DEPTH);

  logic [PW-1:0] head, tail;
  logic [W-1:0]  mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (wr_en) tail <= tail + PW'(1);
      if (rd_en) head <= head + PW'(1);
    end
  end

  // Payload storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[tail] <= wr_data;
  end

  assign rd_data = mem[head];

endmodule

// File: rtl/ibuf_multiway.sv
// N-way in-order instruction buffer between decode and issue.
// Optional DIFFTEST_EN adds a per-op sideband (i_dt/o_dt) stored alongside the payload.
module ibuf_multiway
  import ibuf_multiway_pkg::*;
#(
  parameter int WAYS         = 2,
  parameter int DEPTH        = 8,
  parameter int WIDTH        = 188,
  parameter int READY_MARGIN = 6,
  parameter int DT_WIDTH     = 256
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              interrupt,
  input  logic [$clog2(WAYS+1)-1:0]         i_size,
  input  logic [WAYS-1:0][WIDTH-1:0]        i_data,
  output logic                              i_ready,
  output logic [WAYS-1:0]                   o_valid,
  output logic [WAYS-1:0][WIDTH-1:0]        o_data,
  output logic [WAYS-1:0]                   o_int,
  input  logic [$clog2(WAYS+1)-1:0]         o_size,
  output logic [$clog2(WAYS*DEPTH+1)-1:0]   o_count,
  output logic                              o_overflow
`ifdef DIFFTEST_EN
  ,input  logic [WAYS-1:0][DT_WIDTH-1:0]    i_dt
  ,output logic [WAYS-1:0][DT_WIDTH-1:0]    o_dt
`endif
);
  localparam int CAP = WAYS * DEPTH;
  localparam int CW  = $clog2(CAP + 1);
  localparam int BW  = idx_w(WAYS);
`ifdef DIFFTEST_EN
  localparam int EW  = DT_WIDTH + WIDTH + 1;
`else
  localparam int EW  = WIDTH + 1;
`endif

  logic [CW-1:0]            count, n_in, n_out, room;
  logic [BW-1:0]            head_bank, tail_bank;
  logic [WAYS-1:0][EW-1:0]  rd_q;

  // Reads free slots before writes claim them, so a full buffer can swap WAYS ops.
  always_comb begin
    n_out = (CW'(o_size) > count) ? count : CW'(o_size);
    room  = CW'(CAP) - count + n_out;
    n_in  = (CW'(i_size) > room) ? room : CW'(i_size);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      head_bank  <= '0;
      tail_bank  <= '0;
      o_overflow <= 1'b0;
    end else if (flush) begin
      count      <= '0;
      head_bank  <= '0;
      tail_bank  <= '0;
      o_overflow <= 1'b0;
    end else begin
      count     <= count + n_in - n_out;
      tail_bank <= tail_bank + BW'(n_in);
      head_bank <= head_bank + BW'(n_out);
      if (CW'(i_size) > n_in) o_overflow <= 1'b1;
    end
  end

  for (genvar b = 0; b < WAYS; b++) begin : gen_bank
    // Lane offset of this bank relative to the rotating write/read origin.
    logic [BW-1:0] wofs, rofs;
    logic          wr_en, rd_en;
    logic [EW-1:0] wr_data;

    assign wofs  = BW'(b) - tail_bank;
    assign rofs  = BW'(b) - head_bank;
    assign wr_en = !flush && (CW'(wofs) < n_in);
    assign rd_en = !flush && (CW'(rofs) < n_out);
`ifdef DIFFTEST_EN
    assign wr_data = {i_dt[wofs], interrupt && (wofs == '0), i_data[wofs]};
`else
    assign wr_data = {interrupt && (wofs == '0), i_data[wofs]};
`endif

    ibuf_multiway_way_bank #(.DEPTH(DEPTH), .W(EW)) u_bank (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (rd_q[b])
    );
  end

  for (genvar k = 0; k < WAYS; k++) begin : gen_lane
    logic [BW-1:0] sel;
    assign sel        = head_bank + BW'(k);
    assign o_data[k]  = rd_q[sel][WIDTH-1:0];
    assign o_int[k]   = rd_q[sel][WIDTH];
    assign o_valid[k] = count > CW'(k);
`ifdef DIFFTEST_EN
    assign o_dt[k]    = rd_q[sel][EW-1:WIDTH+1];
`endif
  end

  assign o_count = count;
  assign i_ready = (CAP - int'(count)) >= (READY_MARGIN + WAYS);

  a_osize_clamp: assert property (@(posedge clk) disable iff (reset) (CW'(o_size) <= count))
    else $warning("ibuf_multiway: o_size %0d above count %0d, clamped", o_size, count);

endmodule
